// File: rtl/jt51_op_wrseq.sv
// Operator register write sequencer: holds a CPU operator write until the slot rotation reaches
// its target slot, then strobes the CSR stage for one cen cycle. Optional macro JT51_OPWR_QUEUE_EN.
module jt51_op_wrseq #(
    parameter int unsigned SLOTS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cpu_wr,
    input  logic       a0,
    input  logic [7:0] cpu_din,
    input  logic       clr_ovr,
    output logic [4:0] cur_op,
    output logic [7:0] din,
    output logic       up_dt1_op,
    output logic       up_mul_op,
    output logic       up_tl_op,
    output logic       up_ks_op,
    output logic       up_amsen_op,
    output logic       up_dt2_op,
    output logic       up_d1l_op,
    output logic       up_ar_op,
    output logic       up_d1r_op,
    output logic       up_d2r_op,
    output logic       up_rr_op,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {StIdle, StArmed} state_e;

    state_e     state_q, state_d;
    logic [4:0] cur_op_q, cur_op_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [2:0] grp_q, grp_d;
    logic [4:0] tgt_q, tgt_d;
    logic [7:0] din_q;
    logic       overrun_q, overrun_d;
    logic       ovr_set;
    logic       wr_op;
    logic       fire;

`ifdef JT51_OPWR_QUEUE_EN
    logic       pend_vld_q, pend_vld_d;
    logic [2:0] pend_grp_q, pend_grp_d;
    logic [4:0] pend_tgt_q, pend_tgt_d;
    logic [7:0] pend_data_q, pend_data_d;
`endif

    assign wr_op  = cpu_wr && a0 && (addr_q >= 8'h40);
    assign fire   = (state_q == StArmed) && cen && (cur_op_q == tgt_q);
    assign cur_op = cur_op_q;
    assign busy   = (state_q == StArmed);
    assign din    = fire ? data_q : din_q;
    assign overrun = overrun_q;

    always_comb begin
        cur_op_d = cur_op_q;
        if (cen) begin
            cur_op_d = (cur_op_q == 5'(SLOTS - 1)) ? 5'd0 : cur_op_q + 5'd1;
        end
        addr_d = (cpu_wr && !a0) ? cpu_din : addr_q;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        grp_d   = grp_q;
        tgt_d   = tgt_q;
        ovr_set = 1'b0;
`ifdef JT51_OPWR_QUEUE_EN
        pend_vld_d  = pend_vld_q;
        pend_grp_d  = pend_grp_q;
        pend_tgt_d  = pend_tgt_q;
        pend_data_d = pend_data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (wr_op) begin
                    data_d  = cpu_din;
                    grp_d   = addr_q[7:5];
                    tgt_d   = addr_q[4:0];
                    state_d = StArmed;
                end
            end
            StArmed: begin
`ifdef JT51_OPWR_QUEUE_EN
                if (fire) begin
                    if (pend_vld_q) begin
                        data_d     = pend_data_q;
                        grp_d      = pend_grp_q;
                        tgt_d      = pend_tgt_q;
                        pend_vld_d = 1'b0;
                        ovr_set    = wr_op;
                    end else if (wr_op) begin
                        // Empty buffer at the fire edge: the new write becomes active directly.
                        data_d = cpu_din;
                        grp_d  = addr_q[7:5];
                        tgt_d  = addr_q[4:0];
                    end else begin
                        state_d = StIdle;
                    end
                end else if (wr_op) begin
                    if (pend_vld_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = cpu_din;
                        pend_grp_d  = addr_q[7:5];
                        pend_tgt_d  = addr_q[4:0];
                    end
                end
`else
                ovr_set = wr_op;
                if (fire) begin
                    state_d = StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        overrun_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : overrun_q);
    end

    always_comb begin
        up_dt1_op   = 1'b0;
        up_mul_op   = 1'b0;
        up_tl_op    = 1'b0;
        up_ks_op    = 1'b0;
        up_amsen_op = 1'b0;
        up_dt2_op   = 1'b0;
        up_d1l_op   = 1'b0;
        up_ar_op    = 1'b0;
        up_d1r_op   = 1'b0;
        up_d2r_op   = 1'b0;
        up_rr_op    = 1'b0;
        if (fire) begin
            case (grp_q)
                3'd2: begin up_dt1_op   = 1'b1; up_mul_op = 1'b1; end
                3'd3: begin up_tl_op    = 1'b1;                   end
                3'd4: begin up_ks_op    = 1'b1; up_ar_op  = 1'b1; end
                3'd5: begin up_amsen_op = 1'b1; up_d1r_op = 1'b1; end
                3'd6: begin up_dt2_op   = 1'b1; up_d2r_op = 1'b1; end
                3'd7: begin up_d1l_op   = 1'b1; up_rr_op  = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_op_q  <= 5'd0;
            addr_q    <= 8'd0;
            data_q    <= 8'd0;
            grp_q     <= 3'd0;
            tgt_q     <= 5'd0;
            din_q     <= 8'd0;
            overrun_q <= 1'b0;
`ifdef JT51_OPWR_QUEUE_EN
            pend_vld_q  <= 1'b0;
            pend_grp_q  <= 3'd0;
            pend_tgt_q  <= 5'd0;
            pend_data_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cur_op_q  <= cur_op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            grp_q     <= grp_d;
            tgt_q     <= tgt_d;
            din_q     <= din;
            overrun_q <= overrun_d;
`ifdef JT51_OPWR_QUEUE_EN
            pend_vld_q  <= pend_vld_d;
            pend_grp_q  <= pend_grp_d;
            pend_tgt_q  <= pend_tgt_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_jt51_op_wrseq.sv
// Directed self-checking bench for jt51_op_wrseq; expectations follow JT51_OPWR_QUEUE_EN.
module tb_jt51_op_wrseq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] cpu_din = 8'd0;
    logic       clr_ovr = 1'b0;
    logic [4:0] cur_op;
    logic [7:0] din;
    logic       up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op;
    logic       up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op;
    logic       busy, overrun;
    logic [10:0] ups;

    int nvec = 0;
    int nerr = 0;

    jt51_op_wrseq #(.SLOTS(32)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cpu_wr(cpu_wr), .a0(a0), .cpu_din(cpu_din),
        .clr_ovr(clr_ovr), .cur_op(cur_op), .din(din),
        .up_dt1_op(up_dt1_op), .up_mul_op(up_mul_op), .up_tl_op(up_tl_op),
        .up_ks_op(up_ks_op), .up_amsen_op(up_amsen_op), .up_dt2_op(up_dt2_op),
        .up_d1l_op(up_d1l_op), .up_ar_op(up_ar_op), .up_d1r_op(up_d1r_op),
        .up_d2r_op(up_d2r_op), .up_rr_op(up_rr_op), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Bit order: dt1 mul tl ks amsen dt2 d1l ar d1r d2r rr
    assign ups = {up_dt1_op, up_mul_op, up_tl_op, up_ks_op, up_amsen_op, up_dt2_op,
                  up_d1l_op, up_ar_op, up_d1r_op, up_d2r_op, up_rr_op};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs mid-cycle; outputs are settled 1ns later, well before the next posedge.
    task automatic drive(input logic c, input logic w, input logic a, input logic [7:0] d,
                         input logic clr);
        @(negedge clk);
        cen = c; cpu_wr = w; a0 = a; cpu_din = d; clr_ovr = clr;
        #1;
    endtask

    task automatic wait_op(input logic [4:0] v);
        int k = 0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        while (cur_op != v && k < 64) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            k++;
        end
        check("wait_op", {27'd0, cur_op}, {27'd0, v});
    endtask

    task automatic run(input int n, input int div, output int nf, output logic [10:0] u0,
                       output logic [4:0] op0, output logic [7:0] d0, output logic [4:0] op1,
                       output logic [7:0] d1, output logic [4:0] nxt);
        logic prev = 1'b0;
        nf = 0; u0 = '0; op0 = '0; d0 = '0; op1 = '0; d1 = '0; nxt = '0;
        for (int k = 0; k < n; k++) begin
            drive((k % div) == 0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (prev) nxt = cur_op;
            prev = 1'b0;
            if (ups != 11'd0) begin
                if (nf == 0) begin
                    u0 = ups; op0 = cur_op; d0 = din; prev = 1'b1;
                end else if (nf == 1) begin
                    op1 = cur_op; d1 = din;
                end
                nf++;
            end
        end
    endtask

    task automatic write_op(input logic [7:0] adr, input logic [7:0] dat);
        drive(1'b1, 1'b1, 1'b0, adr, 1'b0);
        drive(1'b1, 1'b1, 1'b1, dat, 1'b0);
    endtask

    int          nf;
    logic [10:0] u0;
    logic [4:0]  op0, op1, nxt;
    logic [7:0]  d0, d1;

    initial begin
        // Reset and free-running counter
        rst_n = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_cur_op", {27'd0, cur_op}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_ups", {21'd0, ups}, 32'd0);
        check("rst_din", {24'd0, din}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            check("count", {27'd0, cur_op}, (i + 1) % 32);
        end
        check("idle_ups", {21'd0, ups}, 32'd0);

        // TL write to slot 5
        write_op(8'h65, 8'h7F);
        run(40, 1, nf, u0, op0, d0, op1, d1, nxt);
        check("tl_nfire", nf, 32'd1);
        check("tl_ups", {21'd0, u0}, 32'h100);
        check("tl_op", {27'd0, op0}, 32'd5);
        check("tl_din", {24'd0, d0}, 32'h7F);
        check("tl_next_op", {27'd0, nxt}, 32'd6);
        check("tl_busy_after", {31'd0, busy}, 32'd0);
        check("tl_din_hold", {24'd0, din}, 32'h7F);

        // KS/AR write to slot 31 with sparse cen
        write_op(8'h9F, 8'hC3);
        check("ks_busy", {31'd0, busy}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("ks_busy_armed", {31'd0, busy}, 32'd1);
        run(110, 3, nf, u0, op0, d0, op1, d1, nxt);
        check("ks_nfire", nf, 32'd1);
        check("ks_ups", {21'd0, u0}, 32'h088);
        check("ks_op", {27'd0, op0}, 32'd31);
        check("ks_din", {24'd0, d0}, 32'hC3);
        check("ks_wrap", {27'd0, nxt}, 32'd0);
        check("ks_busy_after", {31'd0, busy}, 32'd0);

        // Address below 0x40 is not an operator write
        write_op(8'h20, 8'h12);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("low_busy", {31'd0, busy}, 32'd0);
        run(40, 1, nf, u0, op0, d0, op1, d1, nxt);
        check("low_nfire", nf, 32'd0);
        check("low_ovr", {31'd0, overrun}, 32'd0);

        // Back-to-back writes to slots 0 and 1
        wait_op(5'd10);
        write_op(8'h40, 8'h11);
        drive(1'b1, 1'b1, 1'b0, 8'h41, 1'b0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        drive(1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        run(40, 1, nf, u0, op0, d0, op1, d1, nxt);
        check("b2b_ups0", {21'd0, u0}, 32'h600);
        check("b2b_op0", {27'd0, op0}, 32'd0);
        check("b2b_din0", {24'd0, d0}, 32'h11);
`ifdef JT51_OPWR_QUEUE_EN
        check("b2b_nfire", nf, 32'd2);
        check("b2b_op1", {27'd0, op1}, 32'd1);
        check("b2b_din1", {24'd0, d1}, 32'h22);
        check("b2b_ovr", {31'd0, overrun}, 32'd0);
`else
        check("b2b_nfire", nf, 32'd1);
        check("b2b_ovr", {31'd0, overrun}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("b2b_ovr_clr", {31'd0, overrun}, 32'd0);
`endif
        check("b2b_busy_after", {31'd0, busy}, 32'd0);

        // Reset while waiting for slot 20
        wait_op(5'd2);
        write_op(8'h54, 8'h5A);
        wait_op(5'd10);
        check("rw_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rw_cur_op", {27'd0, cur_op}, 32'd0);
        check("rw_busy_rst", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rw_cur_op1", {27'd0, cur_op}, 32'd1);
        run(40, 1, nf, u0, op0, d0, op1, d1, nxt);
        check("rw_nfire", nf, 32'd0);
        check("rw_busy_after", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
